detect_scan_sched: RTL and testbench
====================================

# detect_scan_sched

Scheduler and serial scanner for the 8-bit pattern-detect datapath. Two requesters each present an 8-bit word. The block arbitrates round-robin, accepts one word at a time, and shifts it MSB-first through a 4-bit Mealy pattern matcher. It then returns the match count and requester id. It sits between the switch/register front end and the LED/display result logic, and replaces manual `set` pulsing of the detector.

## Interface
- `PATTERN`, default `4'b1011`: 4-bit sequence detected. Oldest bit is the MSB. Overlapping matches count.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req0` input 1: requester 0 has a word pending. Held until `gnt0`.
- `data0` input 8: requester 0 word. Must be stable while `req0` is high.
- `req1` input 1: requester 1 has a word pending. Held until `gnt1`.
- `data1` input 8: requester 1 word.
- `gnt0` output 1: combinational one-cycle accept of requester 0. Data is captured at the same edge.
- `gnt1` output 1: combinational one-cycle accept of requester 1.
- `busy` output 1: registered. High in SHIFT and DONE.
- `detect` output 1: Mealy output. High during the shift cycle whose bit completes `PATTERN`.
- `done` output 1: registered one-cycle pulse marking the result as valid.
- `done_id` output 1: id of the requester whose word finished. Held until the next `done`.
- `match_cnt` output 3: number of matches in the finished word (0..5). Held until the next `done`.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE behaviour:
  - If no request is pending, stay in IDLE.
  - If exactly one `req` is high, grant it.
  - If both are high, grant the requester other than `last_id`.
  - On a grant: capture the data into an 8-bit shift register, set `cur_id`, clear the bit counter, history and count, then go to SHIFT.
- SHIFT behaviour, 8 cycles with bit counter 0..7:
  - Current bit = `shreg[7]`. Shift left each cycle.
  - `detect` = (bit counter ≥ 3) AND ({hist[2:0], bit} == `PATTERN`).
  - Update `hist` <= {hist[1:0], bit}.
  - On `detect`, `cnt` += 1.
  - Go to DONE after counter 7.
- DONE behaviour, 1 cycle:
  - Pulse `done`.
  - Load `match_cnt` <= `cnt` and `done_id` <= `cur_id`.
  - Set `last_id` <= `cur_id`.
  - Return to IDLE.
- No grants are issued in SHIFT or DONE. Requests wait with no loss.
- History never carries across words. A pattern straddling two words is not detected.
- `cnt` is 3 bits and cannot overflow: at most 5 windows exist in 8 bits.
- Reset values:
  - State IDLE, `last_id` = 1, so `req0` wins the first tie.
  - `gnt0`/`gnt1` = 0, `busy` = 0, `detect` = 0, `done` = 0, `done_id` = 0, `match_cnt` = 0.
  - Shift register, history, counters = 0.
- Reset mid-operation: the scan is aborted and no `done` is produced. Pending requests are served after reset releases; the requester keeps `req` asserted.
- A request dropped before its grant is simply not served.

## Timing
- Grant at cycle T, while in IDLE with `req` high. `gnt` is high in cycle T only.
- SHIFT runs cycles T+1..T+8. Bit k (MSB = k0) is evaluated in cycle T+1+k. `detect` is valid combinationally in that cycle.
- `done`, `match_cnt` and `done_id` are valid in cycle T+9. State is IDLE at T+10, which is the earliest next grant.
- Throughput is one word per 10 cycles. With both requesters continuously requesting, grants alternate 0,1,0,1.
- `busy` is high from T+1 through T+9 inclusive.

## Test plan
- Reset then single word:
  - Stimulus: `rst` high 3 cycles; `req0` = 1, `data0` = `8'b0100_1011`.
  - Required: `gnt0` at T, one `detect` at T+8, `done` at T+9, `match_cnt` = 1, `done_id` = 0.
- Overlap:
  - Stimulus: `data1` = `8'b1011_0110` on `req1`.
  - Required: `detect` at T+4 and T+7, `match_cnt` = 2, `done_id` = 1.
- No match:
  - Stimulus: `data0` = `8'b0011_0101`.
  - Required: `detect` never asserted, `match_cnt` = 0. The previous result holds until this `done`.
- Arbitration:
  - Stimulus: `req0` and `req1` held high together from reset.
  - Required: grant order 0,1,0,1 with grants 10 cycles apart. Never both grants in one cycle. No grant while `busy`.
- Reset mid-scan:
  - Stimulus: assert `rst` for 1 cycle at T+4.
  - Required: no `done`, all outputs at reset values the next cycle, `busy` = 0. With `req0` still high, re-grant 1 cycle after `rst` falls.
- Cross-word boundary:
  - Stimulus: `8'b0000_0101` then `8'b1000_0000`, back to back.
  - Required: `match_cnt` = 0 for both words. History must not carry across words.

Source files
------------

// File: rtl/detect_scan_sched_if.sv
// Request/result bundle for the pattern-detect scan scheduler.
// Latency: none (wiring only).
// Backpressure: requesters hold req/data until their gnt; no grant while a word is in flight.
//
// Signals:
//   req0/req1, data0/data1 : requester side, driven by the requesters
//   gnt0/gnt1              : one-cycle accept back to the requesters
//   busy, detect, done,
//   done_id, match_cnt     : scan status and result, driven by the scheduler
interface detect_scan_sched_if;
  logic       req0;
  logic [7:0] data0;
  logic       req1;
  logic [7:0] data1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       detect;
  logic       done;
  logic       done_id;
  logic [2:0] match_cnt;

  modport slave (
    input  req0, data0, req1, data1,
    output gnt0, gnt1, busy, detect, done, done_id, match_cnt
  );

  modport master (
    output req0, data0, req1, data1,
    input  gnt0, gnt1, busy, detect, done, done_id, match_cnt
  );
endinterface

// File: rtl/detect_scan_sched.sv
// Round-robin scheduler feeding an 8-bit word MSB-first through a 4-bit Mealy pattern matcher.
// Latency: grant at T, bits evaluated T+1..T+8, done/match_cnt/done_id at T+9, next grant at T+10 earliest.
// Backpressure: one word in flight; requests simply wait (no grant) while busy, nothing is lost.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; aborts any scan in flight without a done
//   bus : detect_scan_sched_if.slave (requests, grants, status and result)
module detect_scan_sched #(
  parameter logic [3:0] PATTERN = 4'b1011
) (
  input  logic                clk,
  input  logic                rst,
  detect_scan_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] hist;
  logic [2:0] bitcnt;
  logic [2:0] cnt;
  logic       cur_id;
  logic       last_id;

  logic       busy_q;
  logic       done_q;
  logic       done_id_q;
  logic [2:0] match_cnt_q;

  logic       pick1;
  logic       gnt0_c;
  logic       gnt1_c;
  logic       cur_bit;
  logic       det_c;
  logic [2:0] cnt_next;

  always_comb begin
    // Requester 1 wins when it is alone, or on a tie when requester 0 was served last.
    pick1    = bus.req1 && (!bus.req0 || !last_id);
    // Grants are suppressed while rst is high so the reset cycle shows reset values.
    gnt0_c   = (state == IDLE) && !rst && bus.req0 && !pick1;
    gnt1_c   = (state == IDLE) && !rst && pick1;
    cur_bit  = shreg[7];
    // The first three bits of a word cannot complete a window: history is cleared per word.
    det_c    = (state == SHIFT) && !rst && (bitcnt >= 3'd3) && ({hist, cur_bit} == PATTERN);
    cnt_next = cnt + {2'b00, det_c};
  end

  assign bus.gnt0      = gnt0_c;
  assign bus.gnt1      = gnt1_c;
  assign bus.detect    = det_c;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.done_id   = done_id_q;
  assign bus.match_cnt = match_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= 8'd0;
      hist        <= 3'd0;
      bitcnt      <= 3'd0;
      cnt         <= 3'd0;
      cur_id      <= 1'b0;
      last_id     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      done_id_q   <= 1'b0;
      match_cnt_q <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt0_c || gnt1_c) begin
            shreg  <= gnt1_c ? bus.data1 : bus.data0;
            cur_id <= gnt1_c;
            bitcnt <= 3'd0;
            hist   <= 3'd0;
            cnt    <= 3'd0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          shreg  <= {shreg[6:0], 1'b0};
          hist   <= {hist[1:0], cur_bit};
          bitcnt <= bitcnt + 3'd1;
          cnt    <= cnt_next;
          if (bitcnt == 3'd7) begin
            // Result registers load on the last shift edge so they are valid with done
            // in the DONE cycle; the last bit's detect is folded in via cnt_next.
            state       <= DONE;
            done_q      <= 1'b1;
            match_cnt_q <= cnt_next;
            done_id_q   <= cur_id;
            last_id     <= cur_id;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_scan_sched.sv
// Self-checking bench for detect_scan_sched: directed scenarios plus random traffic,
// every cycle compared against a transaction-level reference model.
module tb_detect_scan_sched;

  localparam logic [3:0] PAT = 4'b1011;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  detect_scan_sched_if bus ();

  detect_scan_sched #(.PATTERN(PAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: one in-flight transaction described by its grant cycle and word.
  bit         m_act  = 1'b0;
  int         m_t0   = 0;
  logic [7:0] m_word = 8'd0;
  bit         m_id   = 1'b0;
  bit         m_last = 1'b1;
  logic [2:0] m_cnt  = 3'd0;
  bit         m_rid  = 1'b0;

  bit keep0 = 1'b0;
  bit keep1 = 1'b0;
  bit saw_g0;
  int ndet;
  int ndone;
  int last_done_cnt;
  int last_done_id;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Window ending at bit k (bit 0 = MSB of the word) holds bits k-3..k, oldest as MSB.
  function automatic bit win_hit(input logic [7:0] w, input int k);
    logic [7:0] s;
    s = w >> (7 - k);
    return (k >= 3) && (s[3:0] == PAT);
  endfunction

  function automatic int count_hits(input logic [7:0] w);
    int n = 0;
    for (int k = 0; k < 8; k++)
      if (win_hit(w, k)) n++;
    return n;
  endfunction

  // One clock cycle: check at the falling edge, then advance past the rising edge.
  task automatic tick();
    bit eg0, eg1, ebusy, edet, edone;
    int off;
    @(negedge clk);
    if (m_act && (cyc - m_t0 == 10)) m_act = 1'b0;
    eg0 = 1'b0; eg1 = 1'b0; ebusy = 1'b0; edet = 1'b0; edone = 1'b0;
    if (rst) begin
      chk("gnt0_in_rst", bus.gnt0, 1'b0);
      chk("gnt1_in_rst", bus.gnt1, 1'b0);
      m_act  = 1'b0;
      m_last = 1'b1;
      m_cnt  = 3'd0;
      m_rid  = 1'b0;
    end else begin
      if (m_act) begin
        off   = cyc - m_t0;
        ebusy = 1'b1;
        if (off <= 8) edet = win_hit(m_word, off - 1);
        if (off == 9) begin
          edone  = 1'b1;
          m_cnt  = 3'(count_hits(m_word));
          m_rid  = m_id;
          m_last = m_id;
        end
      end else if (bus.req0 || bus.req1) begin
        if (bus.req0 && bus.req1) m_id = ~m_last;
        else                      m_id = bus.req1;
        eg0    = !m_id;
        eg1    = m_id;
        m_act  = 1'b1;
        m_t0   = cyc;
        m_word = m_id ? bus.data1 : bus.data0;
      end
      chk("gnt0", bus.gnt0, eg0);
      chk("gnt1", bus.gnt1, eg1);
      chk("busy", bus.busy, ebusy);
      chk("detect", bus.detect, edet);
      chk("done", bus.done, edone);
      chk("match_cnt", bus.match_cnt, m_cnt);
      chk("done_id", bus.done_id, m_rid);
      if (bus.detect) ndet++;
      if (bus.gnt0) saw_g0 = 1'b1;
      if (bus.done) begin
        ndone++;
        last_done_cnt = bus.match_cnt;
        last_done_id  = bus.done_id;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (eg0 && !keep0) bus.req0 = 1'b0;
    if (eg1 && !keep1) bus.req1 = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_gnt0(input string tag);
    int n = 0;
    saw_g0 = 1'b0;
    while (!saw_g0 && n < 30) begin
      tick();
      n++;
    end
    chk(tag, saw_g0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = 8'd0;
    bus.data1 = 8'd0;

    // Reset, then idle cycles showing reset values.
    do_reset(3);
    ticks(2);

    // Single word with one match at the last bit.
    ndet = 0; ndone = 0;
    bus.data0 = 8'b0100_1011;
    bus.req0  = 1'b1;
    ticks(12);
    chk("w1_cnt", last_done_cnt, 1);
    chk("w1_id", last_done_id, 0);
    chk("w1_ndet", ndet, 1);
    chk("w1_ndone", ndone, 1);

    // Overlapping matches on requester 1.
    ndet = 0;
    bus.data1 = 8'b1011_0110;
    bus.req1  = 1'b1;
    ticks(12);
    chk("w2_cnt", last_done_cnt, 2);
    chk("w2_id", last_done_id, 1);
    chk("w2_ndet", ndet, 2);

    // No match; previous result held until this done (checked each cycle by the model).
    ndet = 0;
    bus.data0 = 8'b0011_0101;
    bus.req0  = 1'b1;
    ticks(12);
    chk("w3_cnt", last_done_cnt, 0);
    chk("w3_ndet", ndet, 0);

    // Both requesters held from reset: strict alternation starting with 0.
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    bus.data0 = 8'hB5; bus.data1 = 8'h2D;
    keep0 = 1'b1; keep1 = 1'b1;
    do_reset(2);
    ticks(45);
    keep0 = 1'b0; keep1 = 1'b0;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    ticks(12);

    // Reset mid-scan at T+4 with req0 still asserted: abort, then re-grant right after.
    ndone = 0;
    bus.data0 = 8'($urandom);
    bus.req0  = 1'b1;
    keep0     = 1'b1;
    wait_gnt0("mid_first_gnt");
    ticks(3);
    do_reset(1);
    saw_g0 = 1'b0;
    tick();
    chk("mid_regrant", saw_g0, 1'b1);
    chk("mid_no_done", ndone, 0);
    keep0    = 1'b0;
    bus.req0 = 1'b0;
    ticks(12);

    // Back-to-back words whose boundary would form the pattern.
    ndet = 0; ndone = 0;
    bus.data0 = 8'b0000_0101;
    bus.req0  = 1'b1;
    wait_gnt0("xw_gnt");
    bus.data1 = 8'b1000_0000;
    bus.req1  = 1'b1;
    ticks(22);
    chk("xw_ndet", ndet, 0);
    chk("xw_ndone", ndone, 2);
    chk("xw_cnt", last_done_cnt, 0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      if (!bus.req0 && $urandom_range(0, 2) == 0) begin
        bus.data0 = 8'($urandom);
        bus.req0  = 1'b1;
      end
      if (!bus.req1 && $urandom_range(0, 2) == 0) begin
        bus.data1 = 8'($urandom);
        bus.req1  = 1'b1;
      end
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    ticks(12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
